nios_dp_onchip_memory: RTL and testbench
========================================

// Module: nios_dp_onchip_memory
// PURPOSE
//  Dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) sharing one
//  memory array. Parametrised successor to the single-port on-chip memory: configurable
//  width, depth and read latency. Adds explicit readdatavalid and same-address write
//  collision detection. Sits on the Nios data/instruction fabric as shared program/data store.
// PARAMETERS
//  DATA_WIDTH    32     data bits per word; multiple of 8, range 8..128
//  ADDR_WIDTH    15     word-address bits; depth = 2**ADDR_WIDTH words
//  READ_LATENCY  1      1 or 2 clk cycles from read accept to readdatavalid
//  INIT_FILE     ""     hex image loaded at configuration; "" = contents undefined
// PORTS
//  clk               in   1           system clock, all logic on rising edge
//  reset             in   1           asynchronous, active-high reset
//  clken             in   1           global clock enable; 0 stalls the whole block
//  sN_address        in   ADDR_WIDTH  word address, N = 1,2
//  sN_byteenable     in   DATA_WIDTH/8 write byte lanes
//  sN_chipselect     in   1           port select
//  sN_read           in   1           read request
//  sN_write          in   1           write request
//  sN_writedata      in   DATA_WIDTH  write data
//  sN_readdata       out  DATA_WIDTH  read data, valid when sN_readdatavalid=1
//  sN_readdatavalid  out  1           one-cycle pulse per accepted read
//  collision         out  1           pulse: both ports wrote the same address
//  collision_count   out  16          saturating count of collisions
// BEHAVIOUR
//  - No waitrequest; every request with chipselect=1 and clken=1 is accepted that cycle.
//  - Write accept: chipselect&write&clken. Only lanes with byteenable=1 updated at clk edge.
//  - Read accept: chipselect&read&~write&clken. read&write together on one port = write only;
//    no readdatavalid generated.
//  - Read latency: data and readdatavalid=1 exactly READ_LATENCY enabled cycles after accept.
//    Back-to-back reads every cycle sustained; order preserved per port.
//  - Read-during-write (same port or cross port, same address, same cycle): OLD data returned.
//  - Dual write to same address same cycle: per lane, s1 wins where s1 byteenable=1; s2 lanes
//    not enabled on s1 are written from s2. collision=1 on the following cycle (1-cycle pulse)
//    when lanes overlap (s1_be & s2_be != 0); collision_count increments, saturates at 16'hFFFF.
//  - Different addresses: both ports operate fully independently, no interaction.
//  - clken=0: no accepts; read pipeline, collision logic and memory hold state;
//    readdatavalid forced 0 while clken=0; pending reads emerge after clken returns,
//    latency counted in enabled cycles only.
//  - Reset (async assert, sync to clk on release): sN_readdata=0, sN_readdatavalid=0,
//    collision=0, collision_count=0; in-flight reads discarded (no late valid).
//    Memory contents are NOT cleared by reset.
//  - Address is word-granular; no wrap logic needed (full ADDR_WIDTH decoded, top word =
//    2**ADDR_WIDTH-1).
//  - readdata holds last returned value between valid pulses.
// TESTING
//  1. s1 write addr 0x0010 data 0xDEADBEEF be=4'hF; s2 read 0x0010 next cycle ->
//     s2_readdatavalid after READ_LATENCY, s2_readdata=0xDEADBEEF.
//  2. Preload 0x0020=0x11223344; s1 write 0x0020 be=4'b0101 data 0xAABBCCDD, then read ->
//     0x11BB33DD.
//  3. Same cycle: s1 write 0x0030 0xFFFFFFFF be=4'b0011, s2 write 0x0030 0x00000000 be=4'hF ->
//     word=0x0000FFFF; collision pulse 1 cycle; collision_count=1.
//  4. s1 writes 0x0040=0x5, s2 reads 0x0040 same cycle (old=0x0) -> s2 returns 0x0; reread 0x5.
//  5. 8 back-to-back s1 reads, clken=0 for 3 cycles mid-burst -> 8 valid pulses, in order,
//     none while clken=0; READ_LATENCY=1 and 2 both run.
//  6. Issue read, assert reset before valid -> no readdatavalid; outputs 0; memory word intact.

Source files
------------

// File: rtl/nios_dp_onchip_memory.sv
// Dual-port Avalon-MM on-chip RAM: two independent slaves sharing one word array,
// with 1- or 2-cycle read latency, readdatavalid and same-address write collision tracking.
module nios_dp_onchip_memory #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 15,
  parameter int unsigned READ_LATENCY = 1,
  parameter string       INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,

  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,

  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,

  output logic                    collision,
  output logic [15:0]             collision_count
);

  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CNT_W = 16;

  if (INIT_FILE != "") begin : g_init_image
    // Image preload is attached by the device memory flow; simulated contents start undefined.
  end

  // Port-indexed views of the two slaves (index 0 = s1, 1 = s2).
  logic [1:0][ADDR_WIDTH-1:0] addr_c;
  logic [1:0][BE_W-1:0]       be_c;
  logic [1:0][DATA_WIDTH-1:0] wdata_c;
  logic [1:0]                 wr_acc_c;
  logic [1:0]                 rd_acc_c;
  logic                       same_addr_wr_c;

  assign addr_c   = {s2_address, s1_address};
  assign be_c     = {s2_byteenable, s1_byteenable};
  assign wdata_c  = {s2_writedata, s1_writedata};
  assign wr_acc_c = {s2_chipselect & s2_write & clken,
                     s1_chipselect & s1_write & clken};
  assign rd_acc_c = {s2_chipselect & s2_read & ~s2_write & clken,
                     s1_chipselect & s1_read & ~s1_write & clken};
  assign same_addr_wr_c = wr_acc_c[0] & wr_acc_c[1] & (addr_c[0] == addr_c[1]);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane writes; on a shared address s1 owns every lane it enables.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < BE_W; b++) begin
      if (wr_acc_c[0] && be_c[0][b]) begin
        mem_q[addr_c[0]][b*8 +: 8] <= wdata_c[0][b*8 +: 8];
      end
      if (wr_acc_c[1] && be_c[1][b] && !(same_addr_wr_c && be_c[0][b])) begin
        mem_q[addr_c[1]][b*8 +: 8] <= wdata_c[1][b*8 +: 8];
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] mem_rd_c;
    logic [DATA_WIDTH-1:0] stage_data_c;
    logic                  stage_vld_c;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  vld_q, vld_d;

    // Array read happens before this edge's writes land, so a colliding write returns old data.
    assign mem_rd_c = mem_q[addr_c[p]];

    if (READ_LATENCY >= 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d;
      logic                  pipe_vld_q, pipe_vld_d;

      always_comb begin
        pipe_data_d = pipe_data_q;
        pipe_vld_d  = pipe_vld_q;
        if (clken) begin
          pipe_vld_d = rd_acc_c[p];
          if (rd_acc_c[p]) begin
            pipe_data_d = mem_rd_c;
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          pipe_data_q <= '0;
          pipe_vld_q  <= 1'b0;
        end else begin
          pipe_data_q <= pipe_data_d;
          pipe_vld_q  <= pipe_vld_d;
        end
      end

      assign stage_vld_c  = pipe_vld_q;
      assign stage_data_c = pipe_data_q;
    end else begin : g_lat1
      assign stage_vld_c  = rd_acc_c[p];
      assign stage_data_c = mem_rd_c;
    end

    // Output stage advances only on enabled cycles; readdata holds between returns.
    always_comb begin
      rdata_d = rdata_q;
      vld_d   = vld_q;
      if (clken) begin
        vld_d = stage_vld_c;
        if (stage_vld_c) begin
          rdata_d = stage_data_c;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        rdata_q <= '0;
        vld_q   <= 1'b0;
      end else begin
        rdata_q <= rdata_d;
        vld_q   <= vld_d;
      end
    end
  end

  // A held return is masked during a stall and surfaces on the next enabled cycle.
  assign s1_readdata      = g_port[0].rdata_q;
  assign s1_readdatavalid = g_port[0].vld_q & clken;
  assign s2_readdata      = g_port[1].rdata_q;
  assign s2_readdatavalid = g_port[1].vld_q & clken;

  logic             coll_q, coll_d;
  logic [CNT_W-1:0] coll_cnt_q, coll_cnt_d;

  // Collision flags overlapping lanes only; disjoint-lane merges are legal traffic.
  always_comb begin
    coll_d     = coll_q;
    coll_cnt_d = coll_cnt_q;
    if (clken) begin
      coll_d = same_addr_wr_c & (|(be_c[0] & be_c[1]));
      if (coll_d && (coll_cnt_q != {CNT_W{1'b1}})) begin
        coll_cnt_d = coll_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_q     <= 1'b0;
      coll_cnt_q <= '0;
    end else begin
      coll_q     <= coll_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign collision       = coll_q;
  assign collision_count = coll_cnt_q;

endmodule

// File: tb/tb_nios_dp_onchip_memory.sv
// Scoreboarded bench running READ_LATENCY=1 (dut_a) and READ_LATENCY=2 (dut_b) in lockstep.
module tb_nios_dp_onchip_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        clken;
  logic [7:0]  s1_addr, s2_addr;
  logic [3:0]  s1_be, s2_be;
  logic        s1_cs, s1_rd, s1_wr, s2_cs, s2_rd, s2_wr;
  logic [31:0] s1_wd, s2_wd;

  logic [31:0] a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata;
  logic        a_s1_v, a_s2_v, b_s1_v, b_s2_v;
  logic        a_coll, b_coll;
  logic [15:0] a_cnt, b_cnt;

  logic [31:0] model [256];
  logic [31:0] q_a1[$], q_a2[$], q_b1[$], q_b2[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  nios_dp_onchip_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(1), .INIT_FILE("")) dut_a (
    .clk(clk), .reset(rst), .clken(clken),
    .s1_address(s1_addr), .s1_byteenable(s1_be), .s1_chipselect(s1_cs), .s1_read(s1_rd),
    .s1_write(s1_wr), .s1_writedata(s1_wd), .s1_readdata(a_s1_rdata), .s1_readdatavalid(a_s1_v),
    .s2_address(s2_addr), .s2_byteenable(s2_be), .s2_chipselect(s2_cs), .s2_read(s2_rd),
    .s2_write(s2_wr), .s2_writedata(s2_wd), .s2_readdata(a_s2_rdata), .s2_readdatavalid(a_s2_v),
    .collision(a_coll), .collision_count(a_cnt));

  nios_dp_onchip_memory #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .READ_LATENCY(2), .INIT_FILE("")) dut_b (
    .clk(clk), .reset(rst), .clken(clken),
    .s1_address(s1_addr), .s1_byteenable(s1_be), .s1_chipselect(s1_cs), .s1_read(s1_rd),
    .s1_write(s1_wr), .s1_writedata(s1_wd), .s1_readdata(b_s1_rdata), .s1_readdatavalid(b_s1_v),
    .s2_address(s2_addr), .s2_byteenable(s2_be), .s2_chipselect(s2_cs), .s2_read(s2_rd),
    .s2_write(s2_wr), .s2_writedata(s2_wd), .s2_readdata(b_s2_rdata), .s2_readdatavalid(b_s2_v),
    .collision(b_coll), .collision_count(b_cnt));

  // Pop the scoreboard on every valid pulse; a pulse with nothing pending is an error.
  always @(negedge clk) begin
    logic [31:0] e;
    if (a_s1_v) begin
      n_checks++;
      if (q_a1.size() == 0) begin
        n_fail++; $display("FAIL a_s1_unexpected_valid got data %h, required no valid", a_s1_rdata);
      end else begin
        e = q_a1.pop_front();
        if (a_s1_rdata !== e) begin n_fail++; $display("FAIL a_s1_readdata got %h required %h", a_s1_rdata, e); end
      end
    end
    if (a_s2_v) begin
      n_checks++;
      if (q_a2.size() == 0) begin
        n_fail++; $display("FAIL a_s2_unexpected_valid got data %h, required no valid", a_s2_rdata);
      end else begin
        e = q_a2.pop_front();
        if (a_s2_rdata !== e) begin n_fail++; $display("FAIL a_s2_readdata got %h required %h", a_s2_rdata, e); end
      end
    end
    if (b_s1_v) begin
      n_checks++;
      if (q_b1.size() == 0) begin
        n_fail++; $display("FAIL b_s1_unexpected_valid got data %h, required no valid", b_s1_rdata);
      end else begin
        e = q_b1.pop_front();
        if (b_s1_rdata !== e) begin n_fail++; $display("FAIL b_s1_readdata got %h required %h", b_s1_rdata, e); end
      end
    end
    if (b_s2_v) begin
      n_checks++;
      if (q_b2.size() == 0) begin
        n_fail++; $display("FAIL b_s2_unexpected_valid got data %h, required no valid", b_s2_rdata);
      end else begin
        e = q_b2.pop_front();
        if (b_s2_rdata !== e) begin n_fail++; $display("FAIL b_s2_readdata got %h required %h", b_s2_rdata, e); end
      end
    end
  end

  task automatic idle();
    s1_cs = 0; s1_rd = 0; s1_wr = 0; s1_addr = '0; s1_be = '0; s1_wd = '0;
    s2_cs = 0; s2_rd = 0; s2_wr = 0; s2_addr = '0; s2_be = '0; s2_wd = '0;
    clken = 1;
  endtask

  task automatic set_wr(input int port, input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
    if (port == 1) begin s1_cs = 1; s1_wr = 1; s1_rd = 0; s1_addr = a; s1_wd = d; s1_be = be; end
    else           begin s2_cs = 1; s2_wr = 1; s2_rd = 0; s2_addr = a; s2_wd = d; s2_be = be; end
  endtask

  task automatic set_rd(input int port, input logic [7:0] a);
    if (port == 1) begin s1_cs = 1; s1_rd = 1; s1_wr = 0; s1_addr = a; end
    else           begin s2_cs = 1; s2_rd = 1; s2_wr = 0; s2_addr = a; end
  endtask

  // Advance one clock: reads sample the model first (old data), then writes apply, s1 last.
  task automatic cycle();
    if (clken) begin
      if (s1_cs && s1_rd && !s1_wr) begin q_a1.push_back(model[s1_addr]); q_b1.push_back(model[s1_addr]); end
      if (s2_cs && s2_rd && !s2_wr) begin q_a2.push_back(model[s2_addr]); q_b2.push_back(model[s2_addr]); end
      for (int b = 0; b < 4; b++) begin
        if (s2_cs && s2_wr && s2_be[b]) model[s2_addr][b*8 +: 8] = s2_wd[b*8 +: 8];
      end
      for (int b = 0; b < 4; b++) begin
        if (s1_cs && s1_wr && s1_be[b]) model[s1_addr][b*8 +: 8] = s1_wd[b*8 +: 8];
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (q_a1.size() + q_a2.size() + q_b1.size() + q_b2.size() == 0) break;
      cycle();
    end
    n_checks++;
    if (q_a1.size() + q_a2.size() + q_b1.size() + q_b2.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain pending reads %0d/%0d/%0d/%0d required 0", tag,
               q_a1.size(), q_a2.size(), q_b1.size(), q_b2.size());
    end
  endtask

  task automatic test_reset();
    rst = 1; idle();
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata} !== 128'h0) begin
      n_fail++; $display("FAIL reset_readdata got %h %h %h %h required 0", a_s1_rdata, a_s2_rdata, b_s1_rdata, b_s2_rdata);
    end
    n_checks++;
    if ({a_s1_v, a_s2_v, b_s1_v, b_s2_v, a_coll, b_coll} !== 6'b0 || a_cnt !== 16'h0 || b_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_flags got v=%b%b%b%b coll=%b%b cnt=%h/%h required all 0",
                         a_s1_v, a_s2_v, b_s1_v, b_s2_v, a_coll, b_coll, a_cnt, b_cnt);
    end
    rst = 0;
    cycle();
  endtask

  task automatic test_write_read();
    set_wr(1, 8'h10, 32'hDEADBEEF, 4'hF); cycle(); idle();
    set_rd(2, 8'h10); cycle(); idle();
    drain("write_read");
    n_checks++;
    if (a_s2_rdata !== 32'hDEADBEEF || b_s2_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_read got %h/%h required deadbeef", a_s2_rdata, b_s2_rdata);
    end
  endtask

  task automatic test_byte_lanes();
    set_wr(2, 8'h20, 32'h11223344, 4'hF); cycle(); idle();
    set_wr(1, 8'h20, 32'hAABBCCDD, 4'b0101); cycle(); idle();
    set_rd(1, 8'h20); cycle(); idle();
    drain("byte_lanes");
    n_checks++;
    if (a_s1_rdata !== 32'h11BB33DD || b_s1_rdata !== 32'h11BB33DD) begin
      n_fail++; $display("FAIL byte_lanes got %h/%h required 11bb33dd", a_s1_rdata, b_s1_rdata);
    end
  endtask

  task automatic test_collision();
    set_wr(1, 8'h30, 32'hFFFFFFFF, 4'b0011);
    set_wr(2, 8'h30, 32'h00000000, 4'hF);
    cycle(); idle();
    n_checks++;
    if (a_coll !== 1'b1 || b_coll !== 1'b1 || a_cnt !== 16'd1 || b_cnt !== 16'd1) begin
      n_fail++; $display("FAIL collision_pulse got coll=%b%b cnt=%0d/%0d required 1 1 cnt=1", a_coll, b_coll, a_cnt, b_cnt);
    end
    cycle();
    n_checks++;
    if (a_coll !== 1'b0 || b_coll !== 1'b0 || a_cnt !== 16'd1) begin
      n_fail++; $display("FAIL collision_end got coll=%b%b cnt=%0d required 0 0 cnt=1", a_coll, b_coll, a_cnt);
    end
    set_rd(2, 8'h30); cycle(); idle();
    drain("collision");
    n_checks++;
    if (a_s2_rdata !== 32'h0000FFFF || b_s2_rdata !== 32'h0000FFFF) begin
      n_fail++; $display("FAIL collision_word got %h/%h required 0000ffff", a_s2_rdata, b_s2_rdata);
    end
    // Same address, disjoint lanes: merged word, no collision.
    set_wr(1, 8'h31, 32'h11112222, 4'b0011);
    set_wr(2, 8'h31, 32'h33334444, 4'b1100);
    cycle(); idle();
    n_checks++;
    if (a_coll !== 1'b0 || b_coll !== 1'b0 || a_cnt !== 16'd1 || b_cnt !== 16'd1) begin
      n_fail++; $display("FAIL disjoint_no_collision got coll=%b%b cnt=%0d/%0d required 0 0 cnt=1", a_coll, b_coll, a_cnt, b_cnt);
    end
    set_rd(1, 8'h31); cycle(); idle();
    drain("disjoint");
    n_checks++;
    if (a_s1_rdata !== 32'h33332222 || b_s1_rdata !== 32'h33332222) begin
      n_fail++; $display("FAIL disjoint_word got %h/%h required 33332222", a_s1_rdata, b_s1_rdata);
    end
  endtask

  task automatic test_read_during_write();
    set_wr(2, 8'h40, 32'h0, 4'hF); cycle(); idle();
    set_wr(1, 8'h40, 32'h5, 4'hF); set_rd(2, 8'h40); cycle(); idle();
    set_rd(2, 8'h40); cycle(); idle();
    // Read and write together on one port: write only, no valid expected.
    s1_cs = 1; s1_rd = 1; s1_wr = 1; s1_addr = 8'h41; s1_wd = 32'h77; s1_be = 4'hF; cycle(); idle();
    set_rd(1, 8'h41); cycle(); idle();
    drain("rdw");
    n_checks++;
    if (a_s2_rdata !== 32'h5 || b_s2_rdata !== 32'h5 || a_s1_rdata !== 32'h77) begin
      n_fail++; $display("FAIL rdw_final got s2=%h/%h s1=%h required 5 5 77", a_s2_rdata, b_s2_rdata, a_s1_rdata);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      set_wr(1, 8'(8'h50 + i), 32'hA0A0A000 + 32'(i * 32'h01010101), 4'hF); cycle();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      set_rd(1, 8'(8'h50 + i));
      if (i == 4) begin
        clken = 0;
        for (int k = 0; k < 3; k++) begin
          #1;
          n_checks++;
          if (a_s1_v !== 1'b0 || b_s1_v !== 1'b0) begin
            n_fail++; $display("FAIL stall_valid cycle %0d got %b/%b required 0", k, a_s1_v, b_s1_v);
          end
          cycle();
        end
        clken = 1;
      end
      cycle();
    end
    idle();
    drain("back_to_back");
    // Top word of the array, written on one port and read on the other.
    set_wr(2, 8'hFF, 32'hC0FFEE01, 4'hF); cycle(); idle();
    set_rd(1, 8'hFF); cycle(); idle();
    drain("top_word");
    n_checks++;
    if (a_s1_rdata !== 32'hC0FFEE01 || b_s1_rdata !== 32'hC0FFEE01) begin
      n_fail++; $display("FAIL top_word got %h/%h required c0ffee01", a_s1_rdata, b_s1_rdata);
    end
  endtask

  task automatic test_reset_inflight();
    set_rd(1, 8'h10);
    @(posedge clk); #1;
    rst = 1; idle();
    #1;
    n_checks++;
    if ({a_s1_rdata, b_s1_rdata} !== 64'h0 || {a_s1_v, b_s1_v, a_coll, b_coll} !== 4'b0 || a_cnt !== 16'h0 || b_cnt !== 16'h0) begin
      n_fail++; $display("FAIL reset_inflight_outputs got %h %h v=%b%b cnt=%0d/%0d required all 0",
                         a_s1_rdata, b_s1_rdata, a_s1_v, b_s1_v, a_cnt, b_cnt);
    end
    repeat (2) @(posedge clk);
    #1; rst = 0;
    repeat (4) cycle();
    set_rd(2, 8'h10); cycle(); idle();
    drain("reset_inflight");
    n_checks++;
    if (a_s2_rdata !== 32'hDEADBEEF || b_s2_rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL memory_kept got %h/%h required deadbeef", a_s2_rdata, b_s2_rdata);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_collision();
    test_read_during_write();
    test_back_to_back();
    test_reset_inflight();
    repeat (3) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
